spi_mst: RTL and testbench

- Parametrised next-generation SPI master peripheral on the core's data bus (dcs/drd/dwe/dwst/dadrs/din/dout).
- Adds over the single-byte SPI master:
  - TX and RX FIFOs
  - all four CPOL/CPHA modes
  - LSB-first option
  - NCS software-controlled chip selects
  - sticky error flags
  - a maskable interrupt.
- Frames are 8 bits. SCLK is divided from clk by a power of two.

---
 rtl/spi_mst.sv | 265 ++++++++++++++++++++++++++
 tb/tb_spi_mst.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mst.sv
// SPI master with TX/RX byte FIFOs, four CPOL/CPHA modes, LSB-first option,
// software-owned chip selects, sticky overflow flags and a maskable interrupt.
module spi_mst #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NCS   = 2,
    parameter int unsigned ALSB  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dcs,
    input  logic              drd,
    input  logic              dwe,
    input  logic [XLEN/8-1:0] dwst,
    input  logic [XLEN-1:0]   dadrs,
    input  logic [XLEN-1:0]   din,
    output logic [XLEN-1:0]   dout,
    output logic              irq,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NCS-1:0]    csn
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StLead, StTrail, StDone} state_e;

    state_e          state_q, state_d;
    logic [15:0]     div_q, div_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic            sclk_q, sclk_d, mosi_q, mosi_d;
    logic [9:0]      ctrl_q, ctrl_d;
    logic [NCS-1:0]  csn_q, csn_d;
    logic [XLEN-1:0] dout_q, dout_d;
    logic            irq_q, irq_d, rxovf_q, rxovf_d, txovf_q, txovf_d;
    logic [AW-1:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW-1:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [7:0]      tx_mem_q [DEPTH];
    logic [7:0]      rx_mem_q [DEPTH];

    logic [1:0]      reg_sel;
    logic            wr_en, rd_en, stat_rd;
    logic            cpol, cpha, lsbf, ie_rx, ie_txe;
    logic [3:0]      ld;
    logic [15:0]     tc;
    logic            tx_full, tx_empty, rx_full, rx_empty, idle;
    logic            tx_push_req, tx_push, tx_pop, rx_push_req, rx_push, rx_pop;
    logic [7:0]      tx_head, tx_head_shift, tx_sh_shift, rx_sh_shift;
    logic            tx_head_bit, tx_sh_bit;
    logic [XLEN-1:0] rdata;
    logic            unused_bits;

    assign reg_sel  = dadrs[ALSB+1:ALSB];
    assign wr_en    = dcs & dwe & dwst[0];
    assign rd_en    = dcs & drd;
    assign stat_rd  = rd_en && (reg_sel == 2'd1);
    assign cpol     = ctrl_q[5];
    assign cpha     = ctrl_q[6];
    assign lsbf     = ctrl_q[7];
    assign ie_rx    = ctrl_q[8];
    assign ie_txe   = ctrl_q[9];
    assign tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign idle     = tx_empty && (state_q == StIdle);
    assign tx_head  = tx_mem_q[tx_rptr_q];

    // Bit order helpers: the outgoing bit and the shifted remainder, plus the receive shift.
    assign tx_head_bit   = lsbf ? tx_head[0] : tx_head[7];
    assign tx_head_shift = lsbf ? {1'b0, tx_head[7:1]} : {tx_head[6:0], 1'b0};
    assign tx_sh_bit     = lsbf ? tx_sh_q[0] : tx_sh_q[7];
    assign tx_sh_shift   = lsbf ? {1'b0, tx_sh_q[7:1]} : {tx_sh_q[6:0], 1'b0};
    assign rx_sh_shift   = lsbf ? {miso, rx_sh_q[7:1]} : {rx_sh_q[6:0], miso};

    assign unused_bits = ^{dadrs, din, dwst};

    // Half-period terminal count; log2div of 0 acts as 1 and anything above 15 saturates.
    always_comb begin
        if (ctrl_q[4:0] == 5'd0) begin
            ld = 4'd1;
        end else if (ctrl_q[4]) begin
            ld = 4'd15;
        end else begin
            ld = ctrl_q[3:0];
        end
        tc = (16'd1 << ld) - 16'd1;
    end

    // Shift engine: next state, divider, sclk/mosi and shift registers.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bitcnt_d    = bitcnt_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        tx_pop      = 1'b0;
        rx_push_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                sclk_d = cpol;
                if (!tx_empty) begin
                    tx_pop   = 1'b1;
                    bitcnt_d = 4'd8;
                    div_d    = '0;
                    state_d  = StLead;
                    tx_sh_d  = tx_head;
                    if (!cpha) begin
                        mosi_d  = tx_head_bit;
                        tx_sh_d = tx_head_shift;
                    end
                end
            end
            StLead: begin
                if (div_q == tc) begin
                    div_d   = '0;
                    sclk_d  = ~sclk_q;
                    state_d = StTrail;
                    if (cpha) begin
                        mosi_d  = tx_sh_bit;
                        tx_sh_d = tx_sh_shift;
                    end else begin
                        rx_sh_d = rx_sh_shift;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            StTrail: begin
                if (div_q == tc) begin
                    div_d    = '0;
                    sclk_d   = cpol;
                    bitcnt_d = bitcnt_q - 4'd1;
                    state_d  = (bitcnt_q == 4'd1) ? StDone : StLead;
                    if (cpha) begin
                        rx_sh_d = rx_sh_shift;
                    end else if (bitcnt_q != 4'd1) begin
                        // No bit left to present after the final trailing edge.
                        mosi_d  = tx_sh_bit;
                        tx_sh_d = tx_sh_shift;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            StDone: begin
                rx_push_req = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus side: register writes, FIFO bookkeeping, sticky flags, read mux and irq.
    always_comb begin
        ctrl_d      = ctrl_q;
        csn_d       = csn_q;
        rdata       = '0;
        tx_push_req = wr_en && (reg_sel == 2'd0);
        tx_push     = tx_push_req && (!tx_full || tx_pop);
        rx_pop      = rd_en && (reg_sel == 2'd0) && !rx_empty;
        rx_push     = rx_push_req && (!rx_full || rx_pop);
        // A newly raised flag wins over a clearing STATUS read in the same cycle.
        txovf_d     = (txovf_q & ~stat_rd) | (tx_push_req & ~tx_push);
        rxovf_d     = (rxovf_q & ~stat_rd) | (rx_push_req & ~rx_push);
        tx_wptr_d   = tx_wptr_q + AW'(tx_push);
        tx_rptr_d   = tx_rptr_q + AW'(tx_pop);
        tx_cnt_d    = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_wptr_d   = rx_wptr_q + AW'(rx_push);
        rx_rptr_d   = rx_rptr_q + AW'(rx_pop);
        rx_cnt_d    = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        if (wr_en && (reg_sel == 2'd2)) begin
            ctrl_d[9:8] = din[9:8];
            if (idle) begin
                ctrl_d[7:0] = din[7:0];
            end
        end
        if (wr_en && (reg_sel == 2'd3)) begin
            csn_d = din[NCS-1:0];
        end
        case (reg_sel)
            2'd0: rdata[7:0] = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
            2'd1: begin
                rdata[0]     = idle;
                rdata[1]     = tx_full;
                rdata[2]     = rx_empty;
                rdata[3]     = rxovf_q;
                rdata[4]     = txovf_q;
                rdata[15:8]  = 8'(tx_cnt_q);
                rdata[23:16] = 8'(rx_cnt_q);
            end
            2'd2: rdata[9:0] = ctrl_q;
            default: rdata[NCS-1:0] = csn_q;
        endcase
        dout_d = rd_en ? rdata : dout_q;
        irq_d  = (ie_rx & ~rx_empty) | (ie_txe & idle);
    end

    // FIFO storage; emptiness is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= din[7:0];
        end
        if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= rx_sh_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bitcnt_q  <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ctrl_q    <= 10'h001;
            csn_q     <= '1;
            dout_q    <= '0;
            irq_q     <= 1'b0;
            rxovf_q   <= 1'b0;
            txovf_q   <= 1'b0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bitcnt_q  <= bitcnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ctrl_q    <= ctrl_d;
            csn_q     <= csn_d;
            dout_q    <= dout_d;
            irq_q     <= irq_d;
            rxovf_q   <= rxovf_d;
            txovf_q   <= txovf_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
        end
    end

    assign dout = dout_q;
    assign irq  = irq_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign csn  = csn_q;

endmodule

// File: tb/tb_spi_mst.sv
// Self-checking bench for spi_mst: acts as a bus master and an SPI slave observer.
module tb_spi_mst;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NCS   = 2;
    localparam int unsigned ALSB  = 2;

    logic            clk = 1'b0;
    logic            rst, dcs, drd, dwe;
    logic [3:0]      dwst;
    logic [31:0]     dadrs, din, dout;
    logic            irq, sclk, mosi, miso;
    logic [NCS-1:0]  csn;
    logic            loop_en, miso_inv, miso_tie;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    // Slave side: either echo mosi (optionally inverted) or hold a constant level.
    assign miso = loop_en ? (mosi ^ miso_inv) : miso_tie;

    spi_mst #(.XLEN(XLEN), .DEPTH(DEPTH), .NCS(NCS), .ALSB(ALSB)) dut (
        .clk(clk), .rst(rst), .dcs(dcs), .drd(drd), .dwe(dwe), .dwst(dwst),
        .dadrs(dadrs), .din(din), .dout(dout), .irq(irq), .sclk(sclk),
        .mosi(mosi), .miso(miso), .csn(csn)
    );

    task automatic bus_write(input int unsigned a, input logic [31:0] d);
        @(negedge clk);
        dcs = 1'b1; dwe = 1'b1; dwst = 4'hF; dadrs = a << ALSB; din = d;
        @(negedge clk);
        dcs = 1'b0; dwe = 1'b0;
    endtask

    task automatic bus_read(input int unsigned a, output logic [31:0] d);
        @(negedge clk);
        dcs = 1'b1; drd = 1'b1; dadrs = a << ALSB;
        @(negedge clk);
        d = dout;
        dcs = 1'b0; drd = 1'b0;
    endtask

    // One frame: checks edge count, SCLK period, bits seen by the slave, idle level, RX byte.
    task automatic run_frame(input logic [7:0] b, input int unsigned l2, input logic cp,
                             input logic ch, input logic lf, input logic lp, input logic inv);
        int unsigned half;
        int          lead_t[$];
        int          nbits, ntrail, per;
        logic [7:0]  got, exp_rx;
        logic [31:0] rd;
        logic        prev;
        half     = 1 << ((l2 == 0) ? 1 : l2);
        loop_en  = lp;
        miso_inv = inv;
        exp_rx   = lp ? (b ^ {8{inv}}) : {8{miso_tie}};
        bus_write(2, {24'd0, lf, ch, cp, 5'(l2)});
        bus_write(0, {24'd0, b});
        prev = sclk; nbits = 0; ntrail = 0; got = '0;
        for (int c = 0; c < 16 * int'(half) + 20 && ntrail < 8; c++) begin
            @(negedge clk);
            if (sclk !== prev) begin
                if (sclk !== cp) begin
                    lead_t.push_back(c);
                    if (!ch && nbits < 8) begin got[lf ? nbits : 7 - nbits] = mosi; nbits++; end
                end else begin
                    ntrail++;
                    if (ch && nbits < 8) begin got[lf ? nbits : 7 - nbits] = mosi; nbits++; end
                end
                prev = sclk;
            end
        end
        checks++;
        if (lead_t.size() != 8 || ntrail != 8) begin
            errors++;
            $display("FAIL frame_edges lead %0d trail %0d exp 8 8", lead_t.size(), ntrail);
        end
        per = (lead_t.size() >= 8) ? (lead_t[7] - lead_t[0]) : -1;
        checks++;
        if (per != 14 * int'(half)) begin
            errors++;
            $display("FAIL frame_period got %0d exp %0d", per, 14 * int'(half));
        end
        checks++;
        if (got !== b) begin
            errors++;
            $display("FAIL frame_mosi got %h exp %h", got, b);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (sclk !== cp) begin
            errors++;
            $display("FAIL frame_sclk_idle got %b exp %b", sclk, cp);
        end
        bus_read(1, rd);
        checks++;
        if (rd !== 32'h0001_0001) begin
            errors++;
            $display("FAIL frame_status got %h exp %h", rd, 32'h0001_0001);
        end
        bus_read(0, rd);
        checks++;
        if (rd !== {24'd0, exp_rx}) begin
            errors++;
            $display("FAIL frame_rx got %h exp %h", rd, exp_rx);
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({sclk, mosi, irq, csn} !== {3'b000, {NCS{1'b1}}} || dout !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b%b%b %b %h exp 000 %b 0", sclk, mosi, irq, csn,
                     dout, {NCS{1'b1}});
        end
        bus_read(1, rd);
        checks++;
        if (rd !== 32'h5) begin errors++; $display("FAIL reset_status got %h exp 5", rd); end
        bus_read(2, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL reset_ctrl got %h exp 1", rd); end
        bus_read(3, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL reset_csn got %h exp 3", rd); end
        bus_read(0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", rd); end
        // A DATA write without byte-lane 0 enabled must have no effect.
        @(negedge clk);
        dcs = 1'b1; dwe = 1'b1; dwst = 4'hE; dadrs = 32'd0; din = 32'hFF;
        @(negedge clk);
        dcs = 1'b0; dwe = 1'b0; dwst = 4'hF;
        repeat (2) @(negedge clk);
        bus_read(1, rd);
        checks++;
        if (rd !== 32'h5) begin errors++; $display("FAIL dwst0_ignored got %h exp 5", rd); end
    endtask

    task automatic test_mode0;
        run_frame(8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_mode3;
        miso_tie = 1'b1;
        run_frame(8'h01, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            run_frame(8'($urandom), $urandom_range(0, 2), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'b1, 1'($urandom));
        end
    endtask

    // Fill test. In burst mode the engine takes the first byte one cycle after it lands,
    // so the TX FIFO overflows only on the (DEPTH+2)th back-to-back write.
    task automatic test_fill(input bit burst, input logic inv);
        logic [7:0]  bytes[$];
        logic [31:0] rd, exp;
        int          n;
        n        = burst ? DEPTH + 2 : DEPTH + 1;
        loop_en  = 1'b1;
        miso_inv = inv;
        bus_write(2, 32'h1);
        for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
        if (burst) begin
            @(negedge clk);
            dcs = 1'b1; dwe = 1'b1; dwst = 4'hF; dadrs = 32'd0;
            for (int i = 0; i < n; i++) begin din = {24'd0, bytes[i]}; @(negedge clk); end
            dcs = 1'b0; dwe = 1'b0;
            exp = (DEPTH << 8) | 32'h16;
            bus_read(1, rd);
            checks++;
            if (rd !== exp) begin errors++; $display("FAIL burst_status got %h exp %h", rd, exp); end
            bus_read(1, rd);
            checks++;
            if (rd[4] !== 1'b0) begin errors++; $display("FAIL txovf_clear got %b exp 0", rd[4]); end
        end else begin
            for (int i = 0; i < n; i++) bus_write(0, {24'd0, bytes[i]});
        end
        repeat ((DEPTH + 2) * 40 + 20) @(negedge clk);
        exp = (DEPTH << 16) | 32'h9;
        bus_read(1, rd);
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL fill_status got %h exp %h", rd, exp); end
        for (int i = 0; i < DEPTH; i++) begin
            bus_read(0, rd);
            checks++;
            if (rd !== {24'd0, bytes[i] ^ {8{inv}}}) begin
                errors++;
                $display("FAIL fill_rx[%0d] got %h exp %h", i, rd, bytes[i] ^ {8{inv}});
            end
        end
        bus_read(0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL empty_read got %h exp 0", rd); end
        bus_read(1, rd);
        checks++;
        if (rd !== 32'h5) begin errors++; $display("FAIL fill_final_status got %h exp 5", rd); end
    endtask

    task automatic test_irq;
        logic [7:0]  b;
        logic [31:0] rd;
        logic        prev;
        int          k, r, ntrail;
        b        = 8'h80 | 8'($urandom);
        loop_en  = 1'b1;
        miso_inv = 1'b0;
        bus_write(2, 32'h101);
        bus_write(0, {24'd0, b});
        bus_write(2, 32'h121);
        prev = sclk; ntrail = 0; k = -1; r = -1;
        for (int c = 0; c < 200 && r < 0; c++) begin
            @(negedge clk);
            if (sclk !== prev) begin
                if (sclk === 1'b0) begin ntrail++; if (ntrail == 8) k = c; end
                prev = sclk;
            end
            if (irq === 1'b1) r = c;
        end
        // Last trailing edge, then DONE pushes, then the registered irq follows.
        checks++;
        if (k < 0 || r - k != 2) begin
            errors++;
            $display("FAIL irq_rise got %0d exp %0d", r, k + 2);
        end
        bus_read(2, rd);
        checks++;
        if (rd !== 32'h101) begin errors++; $display("FAIL ctrl_busy_write got %h exp 101", rd); end
        bus_read(0, rd);
        checks++;
        if (rd !== {24'd0, b} || irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_pop_data got %h irq %b exp %h irq 1", rd, irq, b);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b exp 0", irq); end
        bus_write(2, 32'h200);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_txe got %b exp 1", irq); end
        bus_write(2, 32'h001);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_off got %b exp 0", irq); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic        prev;
        int          ntrail;
        loop_en  = 1'b1;
        miso_inv = 1'b0;
        bus_write(2, 32'h021);
        bus_write(3, 32'h0);
        checks++;
        if (csn !== '0) begin errors++; $display("FAIL csn_drive got %b exp 0", csn); end
        bus_write(0, 32'h5A);
        bus_write(0, 32'h3C);
        bus_write(0, 32'hC3);
        prev = sclk; ntrail = 0;
        for (int c = 0; c < 200 && ntrail < 3; c++) begin
            @(negedge clk);
            if (sclk !== prev) begin
                if (sclk === 1'b1) ntrail++;
                prev = sclk;
            end
        end
        checks++;
        if (ntrail != 3) begin errors++; $display("FAIL mid_progress got %0d exp 3", ntrail); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({sclk, mosi, irq, csn} !== {3'b000, {NCS{1'b1}}} || dout !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b%b%b %b %h exp 000 %b 0", sclk, mosi, irq,
                     csn, dout, {NCS{1'b1}});
        end
        bus_read(1, rd);
        checks++;
        if (rd !== 32'h5) begin errors++; $display("FAIL mid_reset_status got %h exp 5", rd); end
        bus_read(2, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL mid_reset_ctrl got %h exp 1", rd); end
    endtask

    initial begin
        rst = 1'b1; dcs = 1'b0; drd = 1'b0; dwe = 1'b0; dwst = 4'hF;
        dadrs = '0; din = '0; loop_en = 1'b1; miso_inv = 1'b0; miso_tie = 1'b0;
        test_reset();
        test_mode0();
        test_mode3();
        test_random();
        test_fill(1'b1, 1'b0);
        test_fill(1'b0, 1'b1);
        test_irq();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
